// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the sequential ALU.
// Pure declarations; no timing of its own.
// Not applicable: carries no handshake.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_MULH = 4'b1010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

  // True for the opcodes that go through the iterative multiplier.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH);
  endfunction

endpackage

// File: rtl/alu_seq_param_if.sv
// Operand/result bus of the sequential ALU with valid/ready on both sides.
// Wires only; no latency.
// in_ready/out_ready carry the back-pressure in each direction.
interface alu_seq_param_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] entrada1;
  logic [WIDTH-1:0] entrada2;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] resultado;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;

  // Producer/consumer side (the EX stage around the ALU).
  modport master (
    output in_valid, entrada1, entrada2, ALUControl, out_ready,
    input  in_ready, out_valid, resultado, zero, carry, overflow, negative
  );

  // ALU side.
  modport slave (
    input  in_valid, entrada1, entrada2, ALUControl, out_ready,
    output in_ready, out_valid, resultado, zero, carry, overflow, negative
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// start at edge k, done high in the cycle before edge k+WIDTH; product valid while done.
// No stall input: once started it runs to completion; caller must not start while busy.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Add the shifted multiplicand when the current multiplier bit is set.
  assign w_acc_nxt = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

  // done marks the last iteration; the product presented then already includes it,
  // so the caller can register the final value on the same edge.
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == LAST);
  assign product = w_acc_nxt;

  // Operand load on start, then one shift-add step per edge until the last bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= {{WIDTH{1'b0}}, a};
      r_mplr  <= b;
    end else if (r_busy) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Registered EX-stage ALU with flags and an iterative MUL/MULH.
// Single-cycle ops: result one edge after accept; MUL/MULH: WIDTH edges after accept.
// Output register holds while out_ready is low; in_ready drops until it can be replaced.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  alu_seq_param_if.slave  bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_neg;
  logic             r_mul_hi;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_start;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_ovf;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_mul_res;

  // A new op may enter only when idle and the output slot is free or being drained
  // this cycle; the multiplier must also be free.
  assign w_in_ready = reset_n && (r_state == ST_IDLE) && !w_mul_busy
                      && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = is_mul_op(bus.ALUControl);
  assign w_start    = w_accept && w_is_mul;

  assign w_shamt = bus.entrada2[SHW-1:0];
  assign w_add   = {1'b0, bus.entrada1} + {1'b0, bus.entrada2};
  assign w_sub   = {1'b0, bus.entrada1} + {1'b0, ~bus.entrada2} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle datapath; carry/overflow only meaningful for ADD/SUB.
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    case (bus.ALUControl)
      ALU_AND: w_alu_res = bus.entrada1 & bus.entrada2;
      ALU_OR:  w_alu_res = bus.entrada1 | bus.entrada2;
      ALU_XOR: w_alu_res = bus.entrada1 ^ bus.entrada2;
      ALU_ADD: begin
        w_alu_res   = w_add[WIDTH-1:0];
        w_alu_carry = w_add[WIDTH];
        w_alu_ovf   = (bus.entrada1[WIDTH-1] == bus.entrada2[WIDTH-1])
                      && (w_add[WIDTH-1] != bus.entrada1[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu_res   = w_sub[WIDTH-1:0];
        w_alu_carry = w_sub[WIDTH];
        w_alu_ovf   = (bus.entrada1[WIDTH-1] != bus.entrada2[WIDTH-1])
                      && (w_sub[WIDTH-1] != bus.entrada1[WIDTH-1]);
      end
      ALU_SLL: w_alu_res = bus.entrada1 << w_shamt;
      ALU_SRL: w_alu_res = bus.entrada1 >> w_shamt;
      ALU_SRA: w_alu_res = $signed(bus.entrada1) >>> w_shamt;
      ALU_SLT: w_alu_res = {{(WIDTH-1){1'b0}},
                            ($signed(bus.entrada1) < $signed(bus.entrada2))};
      default: w_alu_res = '0;
    endcase
  end

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_start),
    .a       (bus.entrada1),
    .b       (bus.entrada2),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  assign w_mul_res = r_mul_hi ? w_product[2*WIDTH-1:WIDTH] : w_product[WIDTH-1:0];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: leave IDLE on a multiply, return when its last iteration completes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)    w_state_nxt = ST_MULT;
      ST_MULT: if (w_mul_done) w_state_nxt = ST_IDLE;
    endcase
  end

  // Remember which half of the product the pending multiply wants.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_mul_hi <= 1'b0;
    else if (w_start) r_mul_hi <= (bus.ALUControl == ALU_MULH);
  end

  // Output register: load on single-cycle accept or multiply completion, else drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_neg       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_res       <= w_alu_res;
      r_zero      <= (w_alu_res == '0);
      r_carry     <= w_alu_carry;
      r_ovf       <= w_alu_ovf;
      r_neg       <= w_alu_res[WIDTH-1];
    end else if ((r_state == ST_MULT) && w_mul_done) begin
      r_out_valid <= 1'b1;
      r_res       <= w_mul_res;
      r_zero      <= (w_mul_res == '0);
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_neg       <= w_mul_res[WIDTH-1];
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.resultado = r_res;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.negative  = r_neg;

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed corner cases plus random ops
// against an arithmetic reference model, with back-pressure and mid-multiply reset.
module tb_alu_seq_param;

  localparam int W = 16;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        n;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_seq_param_if #(.WIDTH(W)) bus();

  alu_seq_param #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic z, c, v, n);
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.v = v; e.n = n;
    return e;
  endfunction

  function automatic exp_t observe();
    return mk(bus.resultado, bus.zero, bus.carry, bus.overflow, bus.negative);
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, s, t, sh;
    longint p;
    logic [15:0] r;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b) % 16;
    p  = longint'(a) * longint'(b);
    c  = 1'b0;
    v  = 1'b0;
    r  = 16'h0000;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd3: r = a ^ b;
      4'd2: begin
        t = int'(a) + int'(b);
        r = t[15:0];
        c = (t > 65535);
        s = sa + sb;
        v = (s > 32767) || (s < -32768);
      end
      4'd6: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 32767) || (s < -32768);
      end
      4'd4: begin t = int'(a) << sh; r = t[15:0]; end
      4'd5: r = a >> sh;
      4'd8: begin s = sa >>> sh; r = s[15:0]; end
      4'd7: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd9: r = p[15:0];
      4'd10: r = p[31:16];
      default: r = 16'h0000;
    endcase
    return mk(r, (r == 16'h0000), c, v, r[15]);
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue one op, wait for its result, optionally stall the consumer, then compare.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, output exp_t got);
    exp_t e;
    int   n, lat, exp_lat;
    bit   seen_rdy;
    e       = model(op, a, b);
    exp_lat = (op == 4'd9 || op == 4'd10) ? 16 : 0;
    bus.ALUControl = op;
    bus.entrada1   = a;
    bus.entrada2   = b;
    bus.in_valid   = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat      = 0;
    seen_rdy = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) seen_rdy = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    chk($sformatf("latency op%0h", op), 32'(lat), 32'(exp_lat));
    if (exp_lat != 0) chk("mul_in_ready_low", 32'(seen_rdy), 32'd0);
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      repeat (stall) begin @(posedge clock); #1; end
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    got = observe();
    chk($sformatf("op%0h a=%h b=%h", op, a, b), 32'(got), 32'(e));
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t        got;
    logic [15:0] a, b;
    logic [3:0]  op;
    bit          seen;
    int          stall;

    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.entrada1   = '0;
    bus.entrada2   = '0;
    bus.ALUControl = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_outputs", 32'(observe()), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Directed corner cases.
    run_op(4'h6, 16'h0003, 16'h0001, 0, got);
    chk("sub_3_1", 32'(got), 32'(mk(16'h0002, 1'b0, 1'b1, 1'b0, 1'b0)));
    run_op(4'h6, 16'h0005, 16'h0005, 0, got);
    chk("sub_5_5", 32'(got), 32'(mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0)));
    run_op(4'h2, 16'h7FFF, 16'h0001, 0, got);
    chk("add_ovf", 32'(got), 32'(mk(16'h8000, 1'b0, 1'b0, 1'b1, 1'b1)));
    run_op(4'h2, 16'hFFFF, 16'h0001, 0, got);
    chk("add_carry", 32'(got), 32'(mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0)));
    run_op(4'h9, 16'd300, 16'd300, 0, got);
    chk("mul_300", 32'(got), 32'(mk(16'h5F90, 1'b0, 1'b0, 1'b0, 1'b0)));
    run_op(4'hA, 16'd300, 16'd300, 2, got);
    chk("mulh_300", 32'(got), 32'(mk(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0)));
    run_op(4'h8, 16'h8000, 16'h0014, 0, got);
    chk("sra_shamt", 32'(got), 32'(mk(16'hF800, 1'b0, 1'b0, 1'b0, 1'b1)));
    run_op(4'h7, 16'hFFFF, 16'h0001, 0, got);
    chk("slt_neg", 32'(got), 32'(mk(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0)));
    run_op(4'hF, 16'h1234, 16'h5678, 0, got);
    chk("illegal_op", 32'(got), 32'(mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0)));

    // Back-pressure: first result held, second op stalls until the consumer is ready.
    @(posedge clock); #1;
    bus.out_ready  = 1'b0;
    bus.ALUControl = 4'h2;
    bus.entrada1   = 16'h1234;
    bus.entrada2   = 16'h0101;
    bus.in_valid   = 1'b1;
    @(posedge clock); #1;
    bus.entrada1 = 16'h0001;
    bus.entrada2 = 16'h0002;
    chk("bp_first", 32'(bus.resultado), 32'h1335);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) begin @(posedge clock); #1; end
    chk("bp_hold", 32'(bus.resultado), 32'h1335);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    chk("bp_second", 32'(bus.resultado), 32'h0003);
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clock); #1;
    chk("bp_drain", 32'(bus.out_valid), 32'd0);

    // Back-to-back single-cycle ops at full rate.
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      bus.ALUControl = 4'h2;
      bus.entrada1   = a;
      bus.entrada2   = b;
      bus.in_valid   = 1'b1;
      chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clock); #1;
      chk("b2b_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_result", 32'(observe()), 32'(model(4'h2, a, b)));
    end
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    chk("b2b_drain", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a multiply discards it.
    bus.ALUControl = 4'h9;
    bus.entrada1   = 16'd300;
    bus.entrada2   = 16'd300;
    bus.in_valid   = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_outputs", 32'(observe()), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clock); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no_stale_product", 32'(seen), 32'd0);
    chk("no_stale_result", 32'(bus.resultado), 32'd0);

    // Random ops with occasional consumer stalls.
    for (int i = 0; i < 150; i++) begin
      op    = 4'($urandom_range(0, 15));
      a     = pick();
      b     = pick();
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(op, a, b, stall, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, registered successor of the processor's EX-stage ALU.
- Generic operand width, 4-bit opcode and full flag set (zero, carry, overflow, negative).
- Adds an iterative multi-cycle unsigned multiplier and valid/ready handshakes on input and output, so the EX stage can stall on long ops and on downstream back-pressure.

Parameters:
- WIDTH, 16, operand/result width in bits; power of two, >= 4.
- SHW, $clog2(WIDTH), derived; shift-amount bits taken from entrada2[SHW-1:0].

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block accepts an op this cycle.
- entrada1  in  WIDTH  operand A.
- entrada2  in  WIDTH  operand B / shift amount.
- ALUControl  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- resultado  out  WIDTH  result.
- zero  out  1  resultado == 0.
- carry  out  1  ADD carry-out; SUB no-borrow (A + ~B + 1 carry-out).
- overflow  out  1  signed overflow for ADD/SUB, else 0.
- negative  out  1  resultado[WIDTH-1].

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR.
  - 0100 SLL; 0101 SRL; 0110 SUB; 0111 SLT (signed A<B -> 1, else 0).
  - 1000 SRA; 1001 MUL (low WIDTH bits of unsigned A*B); 1010 MULH (high WIDTH bits).
  - Any other opcode -> result 0, flags per result, carry = overflow = 0.
- Accept: an op is accepted on a rising edge when in_valid && in_ready.
- in_ready = reset_n && state==IDLE && (!out_valid || out_ready). Combinational; 0 while reset_n is low.
- FSM states:
  - IDLE:
    - Single-cycle op accepted -> result and flags registered on the same edge; out_valid=1 after that edge (latency 1). State stays IDLE.
    - MUL/MULH accepted -> load multiplicand, multiplier and opcode, clear the WIDTH*2 accumulator, count=0; go to MULT.
  - MULT: one shift-add iteration per edge, count++.
    - On the edge where count reaches WIDTH-1 (the WIDTH-th iteration), write the selected half to resultado, set out_valid=1, return to IDLE.
    - Accept at edge k -> out_valid rises after edge k+WIDTH.
    - in_ready=0 throughout MULT.
- Output register:
  - Holds value and flags stable while out_valid && !out_ready.
  - out_valid clears on the edge with out_ready=1 unless a new single-cycle op is accepted on that same edge; then the new result replaces the old one and out_valid stays 1 (back-to-back throughput of 1 op/cycle).
- Flags: computed from the WIDTH-bit result actually presented. MUL/MULH and logic/shift ops force carry = overflow = 0.
- Shifts use entrada2[SHW-1:0] only; upper bits are ignored.
- Arithmetic: ADD/SUB computed at WIDTH+1 bits for carry. Overflow = (A[msb]==B'[msb]) && (R[msb]!=A[msb]), with B' = B for ADD and ~B for SUB.
- Reset (async, any time, including mid-MULT):
  - state=IDLE, count=0, accumulator=0.
  - out_valid=0, resultado=0, all flags 0.
  - The in-flight multiply is discarded and never produces output.
- in_valid with in_ready=0: not accepted; the producer must hold the op until it is accepted.

Decomposition:
- Shared package alu_pkg: opcode localparams (ALU_AND … ALU_MULH), FSM state encodings.
- One sub-module, seq_multiplier:
  - Parameter WIDTH.
  - Ports: start, a, b, busy, done, product[2*WIDTH-1:0].
  - Shift-add datapath and iteration counter.
- Top level keeps the combinational ALU, flag logic, output register and handshake.

Test Plan:
- SUB 0x0003-0x0001, out_ready=1 -> resultado=0x0002, zero=0, carry=1, overflow=0; out_valid exactly 1 cycle after accept.
- SUB 0x0005-0x0005 -> 0x0000, zero=1, carry=1. ADD 0x7FFF+0x0001 -> 0x8000, overflow=1, negative=1, carry=0. ADD 0xFFFF+0x0001 -> 0x0000, carry=1, zero=1.
- MUL 300*300 -> 0x5F90; MULH same operands -> 0x0001. out_valid after exactly 16 cycles; in_ready=0 during all 16.
- Back-pressure: out_ready=0 after an ADD -> result held stable, in_ready=0, a second op stalls. Raise out_ready -> second result appears next edge; back-to-back ADDs with out_ready=1 give 1 result/cycle.
- Reset_n pulsed low 5 cycles into a MUL -> out_valid=0, resultado=0 immediately. After release in_ready=1, and no stale product ever appears.
- SRA 0x8000 by entrada2=0x0014 (low 4 bits = 4) -> 0xF800, negative=1. SLT 0xFFFF<0x0001 -> 0x0001. Opcode 1111 -> 0x0000, zero=1.
